// File: rtl/instruction_prefetch_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instruction_prefetch_memory                                  |
// | Description : Program-loadable instruction store with a sequential         |
// |               prefetcher feeding a small in-order buffer. Supports         |
// |               redirect (flush + restart) and flags out-of-range fetches.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instruction_prefetch_memory #(
  parameter int                 WIDTH      = 24,
  parameter int                 DEPTH      = 256,
  parameter int                 ADDR_W     = 24,
  parameter int                 FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [WIDTH-1:0]  i_load_data,
  input  logic              i_instr_ready,
  output logic              o_instr_valid,
  output logic [WIDTH-1:0]  o_instruction,
  output logic [ADDR_W-1:0] o_instr_pc,
  output logic              o_fault
);

  localparam int C_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_PTR_W = $clog2(FIFO_DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  // One extra bit so DEPTH itself is representable when compared to a PC
  localparam logic [ADDR_W:0]  C_DEPTH_EXT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [C_CNT_W:0] C_FIFO_LIMIT = (C_CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [ADDR_W-1:0]   r_fetch_pc;

  logic [WIDTH-1:0]    r_mem [DEPTH];

  // One-deep read pipeline: the read issued last edge, completing this cycle
  logic                r_inflight;
  logic [ADDR_W-1:0]   r_rd_pc;
  logic                r_rd_fault;
  logic [WIDTH-1:0]    r_rd_data;

  // Prefetch buffer
  logic [WIDTH-1:0]      r_fifo_data  [FIFO_DEPTH];
  logic [ADDR_W-1:0]     r_fifo_pc    [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_fault;
  logic [C_PTR_W-1:0]    r_wr_ptr;
  logic [C_PTR_W-1:0]    r_rd_ptr;
  logic [C_CNT_W-1:0]    r_count;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic                w_fetch_oob;
  logic                w_load_ok;
  logic [C_IDX_W-1:0]  w_fetch_idx;
  logic [C_IDX_W-1:0]  w_load_idx;
  logic                w_fifo_valid;
  logic                w_pop;
  logic                w_push;
  logic [C_CNT_W:0]    w_occ;
  logic                w_issue;
  logic [WIDTH-1:0]    w_push_data;

  assign w_fetch_oob  = ({1'b0, r_fetch_pc}  >= C_DEPTH_EXT);
  assign w_load_ok    = i_load_en && ({1'b0, i_load_addr} < C_DEPTH_EXT);
  assign w_fetch_idx  = r_fetch_pc[C_IDX_W-1:0];
  assign w_load_idx   = i_load_addr[C_IDX_W-1:0];

  assign w_fifo_valid = (r_count != '0);
  // A redirect discards whatever would have moved in or out this cycle
  assign w_pop        = w_fifo_valid && i_instr_ready && !i_redirect;
  assign w_push       = r_inflight && !i_redirect;

  // Space check counts the outstanding read and credits a same-cycle pop,
  // so a full buffer being drained can still issue this cycle.
  assign w_occ = {1'b0, r_count}
               + {{C_CNT_W{1'b0}}, r_inflight}
               - {{C_CNT_W{1'b0}}, w_pop};

  // Issue is allowed from IDLE as well so that the first read goes out on the
  // very first edge Run is seen, with the state moving to FETCH on that edge.
  assign w_issue = i_run && !i_redirect && (r_state != S_FAULT)
                && (w_occ < C_FIFO_LIMIT);

  // Out-of-range reads never touch storage and deliver a zero word
  assign w_push_data = r_rd_fault ? '0 : r_rd_data;

  // ---------------------------------------------------------------------------
  // Storage: one write port, one read port, read-first on address collision
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_mem[w_load_idx] <= i_load_data;
    end
    if (w_issue && !w_fetch_oob) begin
      r_rd_data <= r_mem[w_fetch_idx];
    end
  end

  // Track the outstanding read's address and fault flag alongside the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_rd_pc    <= '0;
      r_rd_fault <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_pc    <= r_fetch_pc;
        r_rd_fault <= w_fetch_oob;
      end
    end
  end

  // Buffer payload write; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr]  <= w_push_data;
      r_fifo_pc[r_wr_ptr]    <= r_rd_pc;
      r_fifo_fault[r_wr_ptr] <= r_rd_fault;
    end
  end

  // Buffer pointers and occupancy; redirect empties the buffer outright
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Fetch sequencer: state and fetch address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
    end else begin
      if (i_redirect) begin
        r_fetch_pc <= i_redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_issue && w_fetch_oob) begin
            r_state <= S_FAULT;
          end else if (i_run) begin
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (i_redirect) begin
            r_state <= i_run ? S_FETCH : S_IDLE;
          end else if (w_issue && w_fetch_oob) begin
            r_state <= S_FAULT;
          end else if (!i_run) begin
            r_state <= S_IDLE;
          end
        end
        S_FAULT: begin
          if (i_redirect) begin
            r_state <= i_run ? S_FETCH : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Head of buffer drives the consumer; zero whenever the buffer is empty
  // ---------------------------------------------------------------------------
  assign o_instr_valid = w_fifo_valid;
  assign o_instruction = w_fifo_valid ? r_fifo_data[r_rd_ptr]  : '0;
  assign o_instr_pc    = w_fifo_valid ? r_fifo_pc[r_rd_ptr]    : '0;
  assign o_fault       = w_fifo_valid ? r_fifo_fault[r_rd_ptr] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_instruction_prefetch_memory.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instruction_prefetch_memory                               |
// | Description : Directed self-checking bench for instruction_prefetch_memory |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instruction_prefetch_memory;

  logic        clk;
  logic        rst_n;
  logic        i_run;
  logic        i_redirect;
  logic [23:0] i_redirect_pc;
  logic        i_load_en;
  logic [23:0] i_load_addr;
  logic [23:0] i_load_data;
  logic        i_instr_ready;
  logic        o_instr_valid;
  logic [23:0] o_instruction;
  logic [23:0] o_instr_pc;
  logic        o_fault;

  int vectors     = 0;
  int miscompares = 0;

  instruction_prefetch_memory dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_run         (i_run),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_load_en     (i_load_en),
    .i_load_addr   (i_load_addr),
    .i_load_data   (i_load_data),
    .i_instr_ready (i_instr_ready),
    .o_instr_valid (o_instr_valid),
    .o_instruction (o_instruction),
    .o_instr_pc    (o_instr_pc),
    .o_fault       (o_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_empty(input string tag);
    chk({tag, ".valid"}, {31'd0, o_instr_valid}, 32'd0);
  endtask

  task automatic expect_head(input string tag, input logic [23:0] pc,
                             input logic [23:0] ins, input logic flt);
    chk({tag, ".valid"}, {31'd0, o_instr_valid}, 32'd1);
    chk({tag, ".pc"},    {8'd0, o_instr_pc},     {8'd0, pc});
    chk({tag, ".instr"}, {8'd0, o_instruction},  {8'd0, ins});
    chk({tag, ".fault"}, {31'd0, o_fault},       {31'd0, flt});
  endtask

  task automatic load(input logic [23:0] a, input logic [23:0] d);
    i_load_en   = 1'b1;
    i_load_addr = a;
    i_load_data = d;
    tick();
    i_load_en   = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    i_run         = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_load_en     = 1'b0;
    i_load_addr   = '0;
    i_load_data   = '0;
    i_instr_ready = 1'b0;

    // Reset state
    tick();
    expect_empty("reset");
    chk("reset.instr", {8'd0, o_instruction}, 32'd0);
    chk("reset.pc",    {8'd0, o_instr_pc},    32'd0);
    chk("reset.fault", {31'd0, o_fault},      32'd0);
    rst_n = 1'b1;

    // Program load: words 0..15 and the last two words; address DEPTH ignored
    for (int i = 0; i < 16; i++) load(24'(i), 24'h000A00 + 24'(i));
    load(24'd254, 24'h000AFE);
    load(24'd255, 24'h000AFF);
    load(24'd256, 24'hBADBAD);

    // Streaming with consumer always ready
    i_run         = 1'b1;
    i_instr_ready = 1'b1;
    tick();
    expect_empty("stream.c1");
    for (int k = 0; k < 6; k++) begin
      tick();
      expect_head($sformatf("stream.pc%0d", k), 24'(k), 24'h000A00 + 24'(k), 1'b0);
    end

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    expect_empty("areset");
    chk("areset.instr", {8'd0, o_instruction}, 32'd0);
    chk("areset.pc",    {8'd0, o_instr_pc},    32'd0);
    chk("areset.fault", {31'd0, o_fault},      32'd0);
    tick();
    rst_n         = 1'b1;
    i_instr_ready = 1'b0;

    // Fill with consumer stalled: restarts at RESET_PC, stops at 4 entries
    tick();
    expect_empty("fill.c1");
    tick();
    expect_head("fill.c2", 24'd0, 24'h000A00, 1'b0);
    tick(); tick(); tick(); tick();
    expect_head("fill.hold", 24'd0, 24'h000A00, 1'b0);
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;
    expect_head("fill.pop1", 24'd1, 24'h000A01, 1'b0);
    tick();
    i_run         = 1'b0;
    i_instr_ready = 1'b1;
    tick();
    expect_head("drain.pc2", 24'd2, 24'h000A02, 1'b0);
    tick();
    expect_head("drain.pc3", 24'd3, 24'h000A03, 1'b0);
    tick();
    expect_head("drain.pc4", 24'd4, 24'h000A04, 1'b0);
    tick();
    expect_empty("drain.end");

    // Refill to full then redirect to 10 (pop request that cycle is dropped)
    i_run         = 1'b1;
    i_instr_ready = 1'b0;
    tick(); tick();
    expect_head("refill.pc5", 24'd5, 24'h000A05, 1'b0);
    tick(); tick(); tick();
    i_redirect    = 1'b1;
    i_redirect_pc = 24'd10;
    i_instr_ready = 1'b1;
    tick();
    i_redirect    = 1'b0;
    expect_empty("redir.r1");
    tick();
    expect_empty("redir.r2");
    tick();
    expect_head("redir.pc10", 24'd10, 24'h000A0A, 1'b0);

    // Load and fetch address 5 on the same edge: old word first, new on refetch
    i_redirect    = 1'b1;
    i_redirect_pc = 24'd5;
    tick();
    i_redirect    = 1'b0;
    i_load_en     = 1'b1;
    i_load_addr   = 24'd5;
    i_load_data   = 24'h5A5A5A;
    tick();
    i_load_en     = 1'b0;
    expect_empty("rfirst.r1");
    tick();
    expect_head("rfirst.old", 24'd5, 24'h000A05, 1'b0);
    tick();
    expect_head("rfirst.pc6", 24'd6, 24'h000A06, 1'b0);
    i_redirect    = 1'b1;
    tick();
    i_redirect    = 1'b0;
    tick();
    tick();
    expect_head("rfirst.new", 24'd5, 24'h5A5A5A, 1'b0);

    // Fetch off the end of storage
    i_redirect    = 1'b1;
    i_redirect_pc = 24'd254;
    tick();
    i_redirect    = 1'b0;
    expect_empty("oob.r1");
    tick();
    tick();
    expect_head("oob.pc254", 24'd254, 24'h000AFE, 1'b0);
    tick();
    expect_head("oob.pc255", 24'd255, 24'h000AFF, 1'b0);
    tick();
    expect_head("oob.pc256", 24'd256, 24'h000000, 1'b1);
    tick();
    expect_empty("oob.stop1");
    tick(); tick(); tick();
    expect_empty("oob.stop4");

    // Leave the fault via redirect to 0; word 0 untouched by the DEPTH load
    i_redirect    = 1'b1;
    i_redirect_pc = 24'd0;
    tick();
    i_redirect    = 1'b0;
    tick();
    tick();
    expect_head("recover.pc0", 24'd0, 24'h000A00, 1'b0);
    tick();
    expect_head("recover.pc1", 24'd1, 24'h000A01, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_prefetch_memory.md
INSTRUCTION_PREFETCH_MEMORY -- requirements
Module: instruction_prefetch_memory

Interface
REQ-001 Parameter WIDTH, 24, instruction word width in bits.
REQ-002 Parameter DEPTH, 256, number of instruction words; addresses 0..DEPTH-1 valid.
REQ-003 Parameter ADDR_W, 24, PC width in bits.
REQ-004 Parameter FIFO_DEPTH, 4, prefetch buffer entries; power of two, >=2.
REQ-005 Parameter RESET_PC, 0, first fetch address after reset.
REQ-006 Clock input 1: single clock, all state on rising edge.
REQ-007 Reset_n input 1: reset is asynchronous and active-low.
REQ-008 Run input 1: fetch enable; 0 pauses issue of new reads.
REQ-009 Redirect input 1: branch/jump; flush buffer and restart fetch at RedirectPC.
REQ-010 RedirectPC input ADDR_W: new fetch address.
REQ-011 LoadEn input 1: program-load write strobe.
REQ-012 LoadAddr input ADDR_W: program-load word address.
REQ-013 LoadData input WIDTH: program-load data.
REQ-014 InstrReady input 1: consumer accepts head entry.
REQ-015 InstrValid output 1: head entry present.
REQ-016 Instruction output WIDTH: head entry instruction word.
REQ-017 InstrPC output ADDR_W: address the head entry was fetched from.
REQ-018 Fault output 1: head entry came from an out-of-range address.

Function
REQ-019 Storage SHALL be DEPTH x WIDTH words with one synchronous read port and one write port; read latency exactly 1 cycle.
REQ-020 LoadEn=1 with LoadAddr<DEPTH SHALL write LoadData at that edge; LoadAddr>=DEPTH SHALL be ignored.
REQ-021 Read and write to the same address in one cycle SHALL return the old word (read-first).
REQ-022 FSM states: IDLE, FETCH, FAULT; reset enters IDLE.
REQ-023 IDLE -> FETCH when Run=1; FETCH -> IDLE when Run=0 (in-flight read still completes and is buffered).
REQ-024 In FETCH a read SHALL issue at FetchPC iff Redirect=0 and (count + inflight) < FIFO_DEPTH, where inflight is the 1-cycle read outstanding.
REQ-025 Each issued read SHALL increment FetchPC by 1 modulo 2^ADDR_W.
REQ-026 A read at FetchPC>=DEPTH SHALL not access storage; the entry pushed one cycle later SHALL carry Instruction=0, Fault=1; FSM -> FAULT, no further issue.
REQ-027 FAULT SHALL leave only on Redirect (-> FETCH if Run=1, else IDLE).
REQ-028 Completed reads SHALL be pushed into the FIFO with their PC, in issue order; overflow SHALL be impossible by REQ-024.
REQ-029 Head pops when InstrValid=1 and InstrReady=1; InstrReady with empty FIFO SHALL have no effect.
REQ-030 Push and pop in the same cycle SHALL leave count unchanged; full FIFO with pop SHALL allow a new issue the same cycle.
REQ-031 Redirect=1 SHALL, at that edge: empty the FIFO, discard the in-flight read, set FetchPC=RedirectPC, issue nothing; pop and push that cycle are dropped.
REQ-032 First read at RedirectPC SHALL issue the cycle after Redirect; its entry SHALL be visible (InstrValid=1) two cycles after Redirect.
REQ-033 Instruction/InstrPC/Fault SHALL be driven from the FIFO head combinationally and hold stable while InstrValid=1 and not popped.
REQ-034 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

Reset
REQ-035 Reset_n=0 SHALL immediately force: state IDLE, FetchPC=RESET_PC, FIFO empty, inflight=0, InstrValid=0, Instruction=0, InstrPC=0, Fault=0.
REQ-036 Storage contents SHALL be unaffected by reset; reset mid-fetch SHALL discard all buffered and in-flight entries.
REQ-037 After Reset_n rises, first read SHALL issue on the first edge with Run=1.

Verification
REQ-038 Load words 0..7 = 24'h000A00+i, Run=1, InstrReady=1 -> InstrValid from cycle 2, InstrPC 0,1,2,... one per cycle, Instruction matching.
REQ-039 InstrReady=0, Run=1 -> exactly FIFO_DEPTH entries buffered (PC 0..3), no further issue; InstrReady=1 one cycle -> PC 4 fetched next cycle.
REQ-040 Redirect with RedirectPC=10 while FIFO full -> InstrValid=0 next cycle, head InstrPC=10 with word 10 two cycles after Redirect.
REQ-041 RedirectPC=DEPTH-2 -> entries DEPTH-2, DEPTH-1 with Fault=0, then PC=DEPTH with Fault=1, Instruction=0; no more entries until Redirect to 0.
REQ-042 LoadEn to address 5 while fetching address 5 same cycle -> entry shows old word; refetch shows new word.
REQ-043 Reset_n pulsed low mid-stream -> outputs zero asynchronously; after release fetch restarts at RESET_PC.
